store_buffer: RTL and testbench

//  Memory stage directly downstream of execute. Queues stores in a DEPTH-entry FIFO and drains them to the data bus.

---
 rtl/store_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_store_buffer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: memory stage that sits directly after execute.
//   Stores are queued in a DEPTH-entry FIFO and written to the data bus one at a time.
//   Loads are served in one of two ways:
//     - Forwarded in the same cycle when the youngest buffered store to the same word wrote all four bytes.
//     - Otherwise read over the same bus.
//   hold_o freezes pc/execute while the presented memory op cannot finish. While hold_o is high the
//   execute-side inputs stay stable, so a stalled op is simply re-evaluated every cycle.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   byte_sel                    access size: 00 byte, 01 half, 10 word, 11 none
//   un_sign                     load extension: 1 zero, 0 sign
//   mem_re, mem_raddr           load request and byte address
//   mem_we, mem_waddr, mem_wdata  store request, byte address and data
//   rd_waddr                    load destination register
//   hold_o                      stall request to pc/execute
//   rd_we_o, rd_waddr_o, rd_wdata_o  load writeback (zero when rd_we_o is low)
//   bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o  bus master outputs
//   bus_ack_i, bus_rdata_i      bus completion and read data
//   dbg_state                   current FSM state (IDLE=0, WR=1, RD=2, RDONE=3)
//
// Bus handshake: bus_req_o rises with stable address, data, byte enables and direction. All of them
// stay unchanged until the cycle in which bus_ack_i is high; that cycle completes the transfer and,
// for reads, bus_rdata_i is valid in it. bus_req_o drops in the following cycle.

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  byte_sel,
  input  logic        un_sign,
  input  logic        mem_re,
  input  logic [31:0] mem_raddr,
  input  logic        mem_we,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  rd_waddr,
  output logic        hold_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_waddr_o,
  output logic [31:0] rd_wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RDONE = 2'd3} state_t;

  state_t state;

  // FIFO storage: word address, byte enables, lane-aligned data
  logic [29:0] ent_addr [DEPTH];
  logic [3:0]  ent_be   [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        bus_req_r, bus_we_r;
  logic [31:0] bus_addr_r, bus_wdata_r;
  logic [3:0]  bus_be_r;
  logic [31:0] rdata_r;

  logic load_valid, store_valid, full, push, pop;
  logic fwd_hit;
  logic any_match;
  logic [3:0]  match_be;
  logic [31:0] match_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Pull the addressed lane out of a word and extend it to 32 bits
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extract = u ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = u ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // A simultaneous load wins; the store is dropped
  assign load_valid  = mem_re & (byte_sel != 2'b11);
  assign store_valid = mem_we & ~mem_re & (byte_sel != 2'b11);
  assign full        = (count == CW'(DEPTH));
  assign push        = store_valid & ~full;
  assign pop         = (state == WR) & bus_ack_i;

  // Store lane alignment
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (byte_sel)
      2'b00: begin
        st_be   = 4'b0001 << mem_waddr[1:0];
        st_data = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = mem_waddr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{mem_wdata[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_data = mem_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  // Walk valid entries oldest to youngest; the last hit is the youngest match
  always_comb begin
    logic [AW-1:0] idx;
    any_match  = 1'b0;
    match_be   = 4'b0000;
    match_data = 32'h0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((CW'(i) < count) && (ent_addr[idx] == mem_raddr[31:2])) begin
        any_match  = 1'b1;
        match_be   = ent_be[idx];
        match_data = ent_data[idx];
      end
    end
  end

  // RDONE is already the writeback of the presented load, so forwarding is suppressed there
  assign fwd_hit = load_valid & any_match & (match_be == 4'b1111) & (state != RDONE);

  // A partial match also stalls; the FSM drains the FIFO in that case and the load becomes a miss
  assign hold_o = (load_valid & ~fwd_hit & (state != RDONE)) | (store_valid & full);

  assign rd_we_o    = (state == RDONE) | fwd_hit;
  assign rd_waddr_o = rd_we_o ? rd_waddr : 5'd0;
  assign rd_wdata_o = (state == RDONE) ? rdata_r :
                      fwd_hit ? extract(match_data, mem_raddr[1:0], byte_sel, un_sign) : 32'h0;

  assign bus_req_o   = bus_req_r;
  assign bus_we_o    = bus_we_r;
  assign bus_addr_o  = bus_addr_r;
  assign bus_wdata_o = bus_wdata_r;
  assign bus_be_o    = bus_be_r;
  assign dbg_state   = state;

  // Entry payload needs no reset: count alone decides which entries are valid
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= mem_waddr[31:2];
      ent_be[wr_ptr]   <= st_be;
      ent_data[wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0;
      bus_wdata_r <= 32'h0;
      bus_be_r    <= 4'b0000;
      rdata_r     <= 32'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (load_valid & ~any_match) begin
            state       <= RD;
            bus_req_r   <= 1'b1;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {mem_raddr[31:2], 2'b00};
            bus_wdata_r <= 32'h0;
            bus_be_r    <= 4'b0000;
          end else if (count != '0) begin
            state       <= WR;
            bus_req_r   <= 1'b1;
            bus_we_r    <= 1'b1;
            bus_addr_r  <= {ent_addr[rd_ptr], 2'b00};
            bus_wdata_r <= ent_data[rd_ptr];
            bus_be_r    <= ent_be[rd_ptr];
          end
        end
        WR: begin
          if (bus_ack_i) begin
            state       <= IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0;
            bus_wdata_r <= 32'h0;
            bus_be_r    <= 4'b0000;
          end
        end
        RD: begin
          if (bus_ack_i) begin
            state      <= RDONE;
            rdata_r    <= extract(bus_rdata_i, mem_raddr[1:0], byte_sel, un_sign);
            bus_req_r  <= 1'b0;
            bus_addr_r <= 32'h0;
          end
        end
        RDONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer (DEPTH=4).
// The bench covers:
//   - Forwarding and bus-read extraction, driven from two vector tables.
//   - Multi-cycle corner cases as hand-written sequences: reset mid-write, a full FIFO, and a partial-match stall.
// Inputs are driven 1 time unit after posedge. Outputs are sampled on negedge.

module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  byte_sel;
  logic        un_sign;
  logic        mem_re;
  logic [31:0] mem_raddr;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [4:0]  rd_waddr;
  logic        hold_o;
  logic        rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [1:0]  dbg_state;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .byte_sel(byte_sel), .un_sign(un_sign),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .rd_waddr(rd_waddr), .hold_o(hold_o), .rd_we_o(rd_we_o),
    .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // Expected bus writes: {addr[31:0], be[3:0], wdata[31:0]}
  logic [67:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        u;
    logic [4:0]  rd;
    logic [31:0] exp_data;
  } fwd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        u;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } rd_vec_t;

  fwd_vec_t fwd_tab[8];
  rd_vec_t  rd_tab[5];

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    byte_sel  = 2'b11;
    un_sign   = 1'b0;
    mem_raddr = 32'h0;
    mem_waddr = 32'h0;
    mem_wdata = 32'h0;
    rd_waddr  = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Present a store for one accepted cycle and record the bus write it must produce
  task automatic do_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    mem_we    = 1'b1;
    mem_re    = 1'b0;
    byte_sel  = sz;
    mem_waddr = addr;
    mem_wdata = data;
    @(negedge clk);
    chk("store_hold", {31'h0, hold_o}, 32'h0);
    tick();
    idle_in();
    exp_q.push_back({addr & 32'hFFFF_FFFC, exp_be, exp_wdata});
  endtask

  task automatic wait_bus(input logic we, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_req_o && (bus_we_o == we)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for bus_req_o with bus_we_o=%0b", name, we);
    end
  endtask

  // Scoreboard: next bus write must match the oldest expected entry
  task automatic drain_one(input string name);
    bit ok;
    logic [67:0] e;
    wait_bus(1'b1, name, ok);
    if (ok) begin
      e = exp_q.pop_front();
      chk({name, "_addr"},  bus_addr_o,          e[67:36]);
      chk({name, "_be"},    {28'h0, bus_be_o},   {28'h0, e[35:32]});
      chk({name, "_wdata"}, bus_wdata_o,         e[31:0]);
      bus_ack_i = 1'b1;
      tick();
      bus_ack_i = 1'b0;
    end
  endtask

  // Complete a load that is already presented: wait for the read, ack it, check writeback
  task automatic finish_read(input string name, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input logic [4:0] exp_rd);
    bit ok;
    wait_bus(1'b0, name, ok);
    if (ok) begin
      chk({name, "_raddr"}, bus_addr_o,        exp_addr);
      chk({name, "_rbe"},   {28'h0, bus_be_o}, 32'h0);
      chk({name, "_rhold"}, {31'h0, hold_o},   32'h1);
      bus_ack_i   = 1'b1;
      bus_rdata_i = rdata;
      tick();
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0;
      @(negedge clk);
      chk({name, "_rdwe"},   {31'h0, rd_we_o},    32'h1);
      chk({name, "_rddata"}, rd_wdata_o,          exp_data);
      chk({name, "_rdaddr"}, {27'h0, rd_waddr_o}, {27'h0, exp_rd});
      chk({name, "_rdhold"}, {31'h0, hold_o},     32'h0);
      tick();
      idle_in();
      @(negedge clk);
      chk({name, "_rdwe_1cyc"}, {31'h0, rd_we_o}, 32'h0);
      tick();
    end
  endtask

  task automatic present_load(input logic [31:0] addr, input logic [1:0] sz, input logic u,
                              input logic [4:0] rd);
    mem_re    = 1'b1;
    mem_we    = 1'b0;
    byte_sel  = sz;
    un_sign   = u;
    mem_raddr = addr;
    rd_waddr  = rd;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;

    fwd_tab[0] = '{32'h8000_0004, 2'b00, 1'b0, 5'd1,  32'hFFFF_FFEF};
    fwd_tab[1] = '{32'h8000_0005, 2'b00, 1'b1, 5'd2,  32'h0000_00BE};
    fwd_tab[2] = '{32'h8000_0006, 2'b00, 1'b0, 5'd3,  32'hFFFF_FFAD};
    fwd_tab[3] = '{32'h8000_0007, 2'b00, 1'b0, 5'd4,  32'hFFFF_FFDE};
    fwd_tab[4] = '{32'h8000_0004, 2'b01, 1'b1, 5'd5,  32'h0000_BEEF};
    fwd_tab[5] = '{32'h8000_0006, 2'b01, 1'b0, 5'd6,  32'hFFFF_DEAD};
    fwd_tab[6] = '{32'h8000_0005, 2'b01, 1'b0, 5'd7,  32'hFFFF_BEEF};
    fwd_tab[7] = '{32'h8000_0004, 2'b10, 1'b0, 5'd31, 32'hDEAD_BEEF};

    rd_tab[0] = '{32'h0000_0202, 2'b01, 1'b0, 5'd10, 32'h8001_1234, 32'h0000_0200, 32'hFFFF_8001};
    rd_tab[1] = '{32'h0000_0200, 2'b01, 1'b1, 5'd11, 32'h8001_1234, 32'h0000_0200, 32'h0000_1234};
    rd_tab[2] = '{32'h0000_0103, 2'b00, 1'b0, 5'd12, 32'h1234_5680, 32'h0000_0100, 32'h0000_0012};
    rd_tab[3] = '{32'h0000_0100, 2'b00, 1'b1, 5'd13, 32'h0000_0080, 32'h0000_0100, 32'h0000_0080};
    rd_tab[4] = '{32'h0000_030C, 2'b10, 1'b0, 5'd14, 32'hCAFE_F00D, 32'h0000_030C, 32'hCAFE_F00D};

    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_hold",   {31'h0, hold_o},    32'h0);
    chk("rst_rdwe",   {31'h0, rd_we_o},   32'h0);
    chk("rst_rddata", rd_wdata_o,         32'h0);
    chk("rst_req",    {31'h0, bus_req_o}, 32'h0);
    chk("rst_addr",   bus_addr_o,         32'h0);
    chk("rst_be",     {28'h0, bus_be_o},  32'h0);
    chk("rst_state",  {30'h0, dbg_state}, 32'h0);
    tick();

    // byte_sel=11 load/store is a no-op
    present_load(32'h0000_0040, 2'b11, 1'b0, 5'd9);
    @(negedge clk);
    chk("nop_ld_hold", {31'h0, hold_o},  32'h0);
    chk("nop_ld_rdwe", {31'h0, rd_we_o}, 32'h0);
    tick();
    idle_in();
    mem_we = 1'b1; byte_sel = 2'b11; mem_waddr = 32'h40; mem_wdata = 32'h1;
    @(negedge clk);
    chk("nop_st_hold", {31'h0, hold_o}, 32'h0);
    tick();
    idle_in();
    tick();
    @(negedge clk);
    chk("nop_no_bus", {31'h0, bus_req_o}, 32'h0);
    tick();

    // Forwarding from a buffered word store; bus write is held off with ack low
    do_store(32'h8000_0004, 2'b10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) begin
      present_load(fwd_tab[i].addr, fwd_tab[i].sz, fwd_tab[i].u, fwd_tab[i].rd);
      @(negedge clk);
      chk($sformatf("fwd%0d_rdwe", i),   {31'h0, rd_we_o},    32'h1);
      chk($sformatf("fwd%0d_data", i),   rd_wdata_o,          fwd_tab[i].exp_data);
      chk($sformatf("fwd%0d_rd", i),     {27'h0, rd_waddr_o}, {27'h0, fwd_tab[i].rd});
      chk($sformatf("fwd%0d_hold", i),   {31'h0, hold_o},     32'h0);
      chk($sformatf("fwd%0d_noread", i), {31'h0, bus_req_o & ~bus_we_o}, 32'h0);
      tick();
    end
    idle_in();
    drain_one("fwd_drain");

    // Bus-read extraction table
    for (int i = 0; i < 5; i++) begin
      present_load(rd_tab[i].addr, rd_tab[i].sz, rd_tab[i].u, rd_tab[i].rd);
      @(negedge clk);
      chk($sformatf("rd%0d_hold", i), {31'h0, hold_o}, 32'h1);
      finish_read($sformatf("rd%0d", i), rd_tab[i].rdata, rd_tab[i].exp_addr,
                  rd_tab[i].exp_data, rd_tab[i].rd);
    end

    // Halfword store alignment
    do_store(32'h0000_0306, 2'b01, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    drain_one("sh306");

    // Partial-match load stalls until the byte store drains, then reads the bus
    do_store(32'h0000_0100, 2'b00, 32'h0000_0080, 4'b0001, 32'h8080_8080);
    present_load(32'h0000_0100, 2'b00, 1'b0, 5'd8);
    @(negedge clk);
    chk("part_hold0", {31'h0, hold_o},  32'h1);
    chk("part_rdwe0", {31'h0, rd_we_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("part_hold1", {31'h0, hold_o},   32'h1);
    chk("part_wr",    {31'h0, bus_we_o}, 32'h1);
    drain_one("part_drain");
    finish_read("part_rd", 32'h0000_0080, 32'h0000_0100, 32'hFFFF_FF80, 5'd8);

    // Full FIFO: 5 word stores, ack delayed 3 cycles
    for (int k = 0; k < 4; k++)
      do_store(32'h0000_1000 + 32'(4 * k), 2'b10, 32'h1111_0000 + 32'(k), 4'b1111,
               32'h1111_0000 + 32'(k));
    mem_we = 1'b1; byte_sel = 2'b10; mem_waddr = 32'h0000_1010; mem_wdata = 32'h1111_0004;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("full_hold%0d", c), {31'h0, hold_o}, 32'h1);
      tick();
    end
    drain_one("full_s0");
    @(negedge clk);
    chk("full_hold_after_pop", {31'h0, hold_o}, 32'h0);
    tick();
    idle_in();
    exp_q.push_back({32'h0000_1010, 4'b1111, 32'h1111_0004});
    for (int k = 1; k < 5; k++) drain_one($sformatf("full_s%0d", k));
    chk("full_q_empty", exp_q.size(), 32'h0);

    // Hold during ack cycle with a full FIFO (pop in the same cycle still holds)
    for (int k = 0; k < 4; k++)
      do_store(32'h0000_3000 + 32'(4 * k), 2'b10, 32'h3333_0000 + 32'(k), 4'b1111,
               32'h3333_0000 + 32'(k));
    mem_we = 1'b1; byte_sel = 2'b10; mem_waddr = 32'h0000_3010; mem_wdata = 32'h3333_0004;
    wait_bus(1'b1, "full_ack_wait", ok);
    bus_ack_i = 1'b1;
    #1;
    chk("full_hold_on_ack", {31'h0, hold_o}, 32'h1);
    tick();
    bus_ack_i = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("full_hold_freed", {31'h0, hold_o}, 32'h0);
    tick();
    idle_in();
    exp_q.push_back({32'h0000_3010, 4'b1111, 32'h3333_0004});
    for (int k = 1; k < 5; k++) drain_one($sformatf("full2_s%0d", k));

    // Reset mid-write with 3 entries buffered discards everything
    do_store(32'h0000_2000, 2'b10, 32'h2222_0000, 4'b1111, 32'h2222_0000);
    do_store(32'h0000_2004, 2'b10, 32'h2222_0001, 4'b1111, 32'h2222_0001);
    do_store(32'h0000_2008, 2'b10, 32'h2222_0002, 4'b1111, 32'h2222_0002);
    @(negedge clk);
    chk("mid_wr_req", {31'h0, bus_req_o & bus_we_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstwr_req",   {31'h0, bus_req_o}, 32'h0);
    chk("rstwr_hold",  {31'h0, hold_o},    32'h0);
    chk("rstwr_state", {30'h0, dbg_state}, 32'h0);
    tick();
    present_load(32'h0000_2004, 2'b10, 1'b0, 5'd3);
    @(negedge clk);
    chk("rstwr_nofwd", {31'h0, rd_we_o}, 32'h0);
    chk("rstwr_miss",  {31'h0, hold_o},  32'h1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
